// File: rtl/port_arbiter_if.sv
// Link-side bundle for port_arbiter: requester handshake, outbound byte stream and status.
// The arbiter takes the slave view; the requester/downstream side drives through master.
interface port_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0][31:0]  pkt_in;
  logic [NUM_REQ-1:0]        grant;
  logic                      free_outbound;
  logic                      put_outbound;
  logic [7:0]                payload_outbound;
  logic                      busy;
  logic [15:0]               sent_count;

  modport master (
    output req, pkt_in, free_outbound,
    input  grant, put_outbound, payload_outbound, busy, sent_count
  );

  modport slave (
    input  req, pkt_in, free_outbound,
    output grant, put_outbound, payload_outbound, busy, sent_count
  );
endinterface

// File: rtl/port_arbiter.sv
// Round-robin arbiter that picks one of four requesters and serializes its
// 32-bit packet MSB-first onto a byte-wide outbound link, one idle cycle between packets.
module port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int PKT_BYTES = 4
) (
  input  logic           clock,
  input  logic           reset,
  port_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [1:0] LAST_BYTE = 2'(PKT_BYTES - 1);

  state_t              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [31:0]         shift_q, shift_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic                put_q, put_d;
  logic [7:0]          payload_q, payload_d;
  logic                busy_q, busy_d;
  logic [15:0]         sent_count_q, sent_count_d;

  // Search order starts at the pointer and rotates, so cand[0] has top priority.
  logic [1:0] cand [NUM_REQ];
  logic [1:0] winner;
  logic       win_found;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      assign cand[gi] = ptr_q + 2'(gi);
    end
  endgenerate

  always_comb begin
    win_found = 1'b0;
    winner    = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && bus.req[cand[k]]) begin
        win_found = 1'b1;
        winner    = cand[k];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    grant_d      = '0;
    put_d        = put_q;
    payload_d    = payload_q;
    sent_count_d = sent_count_q;

    case (state_q)
      IDLE: begin
        put_d = 1'b0;
        if (bus.free_outbound && win_found) begin
          grant_d    = NUM_REQ'(1) << winner;
          ptr_d      = winner + 2'd1;
          payload_d  = bus.pkt_in[winner][31:24];
          shift_d    = bus.pkt_in[winner] << 8;
          byte_cnt_d = 2'd0;
          put_d      = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        // Inputs are ignored here: a started packet always runs to its last byte.
        if (byte_cnt_q == LAST_BYTE) begin
          put_d        = 1'b0;
          byte_cnt_d   = 2'd0;
          sent_count_d = sent_count_q + 16'd1;
          state_d      = IDLE;
        end else begin
          payload_d  = shift_q[31:24];
          shift_d    = shift_q << 8;
          byte_cnt_d = byte_cnt_q + 2'd1;
          put_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == SEND);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      ptr_q        <= 2'd0;
      byte_cnt_q   <= 2'd0;
      shift_q      <= '0;
      grant_q      <= '0;
      put_q        <= 1'b0;
      payload_q    <= 8'h00;
      busy_q       <= 1'b0;
      sent_count_q <= 16'h0000;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      shift_q      <= shift_d;
      grant_q      <= grant_d;
      put_q        <= put_d;
      payload_q    <= payload_d;
      busy_q       <= busy_d;
      sent_count_q <= sent_count_d;
    end
  end

  assign bus.grant            = grant_q;
  assign bus.put_outbound     = put_q;
  assign bus.payload_outbound = payload_q;
  assign bus.busy             = busy_q;
  assign bus.sent_count       = sent_count_q;

endmodule

// File: tb/tb_port_arbiter.sv
// Bench for port_arbiter: directed scenarios plus random traffic, checked each cycle
// against a packet-level model (byte queue per transfer, rotating priority index).
module tb_port_arbiter;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  port_arbiter_if bus ();

  port_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit hold_req    = 1'b0;

  // Reference model state
  logic [3:0]  m_grant;
  logic        m_put;
  logic        m_busy;
  logic [7:0]  m_payload;
  logic        m_pay_valid;
  logic [15:0] m_count;
  int          m_ptr;
  logic [7:0]  m_pend [$];

  logic [3:0]  grants_seen [$];
  logic [3:0]  exp_order [5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst_i, input logic [3:0] req_i,
                            input logic [3:0][31:0] pkt_i, input logic free_i);
    logic [31:0] packet;
    int          w;
    bit          found;
    if (rst_i) begin
      m_grant = '0; m_put = 1'b0; m_busy = 1'b0; m_payload = 8'h00;
      m_pay_valid = 1'b1; m_count = '0; m_ptr = 0;
      m_pend.delete();
    end else if (m_busy) begin
      m_grant = '0;
      if (m_pend.size() == 0) begin
        m_put = 1'b0; m_busy = 1'b0; m_pay_valid = 1'b0;
        m_count = m_count + 16'd1;
      end else begin
        m_payload = m_pend.pop_front();
      end
    end else begin
      m_grant = '0; m_put = 1'b0; m_pay_valid = 1'b0;
      found = 1'b0; w = 0;
      if (free_i) begin
        for (int k = 0; k < 4; k++) begin
          if (!found && req_i[(m_ptr + k) % 4]) begin
            found = 1'b1;
            w = (m_ptr + k) % 4;
          end
        end
      end
      if (found) begin
        packet      = pkt_i[w];
        m_payload   = packet[31:24];
        m_pend      = '{packet[23:16], packet[15:8], packet[7:0]};
        m_grant     = 4'(1 << w);
        m_ptr       = (w + 1) % 4;
        m_put       = 1'b1;
        m_busy      = 1'b1;
        m_pay_valid = 1'b1;
      end
    end
  endtask

  // One clock: apply inputs, let the edge happen, compare on the falling edge.
  task automatic tick(input logic rst_i, input logic free_i);
    reset = rst_i;
    bus.free_outbound = free_i;
    @(posedge clock);
    model_edge(rst_i, bus.req, bus.pkt_in, free_i);
    @(negedge clock);
    chk("grant", 32'(bus.grant), 32'(m_grant));
    chk("put", 32'(bus.put_outbound), 32'(m_put));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("sent_count", 32'(bus.sent_count), 32'(m_count));
    if (m_pay_valid) chk("payload", 32'(bus.payload_outbound), 32'(m_payload));
    if (bus.grant != 0) grants_seen.push_back(bus.grant);
    if (!hold_req) bus.req = bus.req & ~m_grant;
  endtask

  initial begin
    bus.req = '0;
    bus.pkt_in = '0;
    bus.free_outbound = 1'b0;
    reset = 1'b1;
    @(negedge clock);

    // Reset state
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);

    // Single requester with a known packet
    bus.pkt_in[0] = 32'hDEADBEEF;
    bus.req = 4'b0001;
    repeat (7) tick(1'b0, 1'b1);
    chk("single_count", 32'(bus.sent_count), 32'd1);

    // All requesting, pointer freshly reset
    tick(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) bus.pkt_in[i] = $urandom;
    hold_req = 1'b1;
    bus.req = 4'hF;
    grants_seen.delete();
    repeat (25) tick(1'b0, 1'b1);
    hold_req = 1'b0;
    bus.req = '0;
    repeat (2) tick(1'b0, 1'b1);
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    chk("rr_grant_total", 32'(grants_seen.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < grants_seen.size()) chk("rr_grant_order", 32'(grants_seen[i]), 32'(exp_order[i]));
      else chk("rr_grant_missing", 32'hFFFF_FFFF, 32'(exp_order[i]));
    end

    // Backpressure then release
    tick(1'b1, 1'b0);
    bus.pkt_in[2] = $urandom;
    bus.req = 4'b0100;
    repeat (10) tick(1'b0, 1'b0);
    repeat (6) tick(1'b0, 1'b1);

    // free drops after byte 1; transfer still completes, nothing new starts
    bus.pkt_in[0] = $urandom;
    bus.req = 4'b0001;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    repeat (3) tick(1'b0, 1'b0);
    bus.req = 4'b0001;
    repeat (4) tick(1'b0, 1'b0);

    // Reset during byte 2, then port 0 before port 3
    repeat (5) tick(1'b0, 1'b1);
    bus.req = 4'b0001;
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    chk("abort_count", 32'(bus.sent_count), 32'd0);
    bus.pkt_in[0] = $urandom;
    bus.pkt_in[3] = $urandom;
    bus.req = 4'b1001;
    repeat (12) tick(1'b0, 1'b1);

    // Random traffic with occasional resets
    repeat (400) begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
          bus.pkt_in[i] = $urandom;
          bus.req[i] = 1'b1;
        end
      end
      tick(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0));
    end

    // Counter wrap: preload near the top while idle, then finish two packets
    bus.req = '0;
    repeat (6) tick(1'b0, 1'b0);
    force dut.sent_count_q = 16'hFFFE;
    m_count = 16'hFFFE;
    tick(1'b0, 1'b0);
    release dut.sent_count_q;
    hold_req = 1'b1;
    bus.pkt_in[1] = $urandom;
    bus.req = 4'b0010;
    repeat (12) tick(1'b0, 1'b1);
    chk("wrap_count", 32'(bus.sent_count), 32'h0000);
    hold_req = 1'b0;
    bus.req = '0;
    repeat (4) tick(1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/port_arbiter.md
PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, is the number of requesters sharing one outbound link; this revision supports exactly 4.
REQ-002 Parameter PKT_BYTES, default 4, is the number of bytes per packet on the link; it matches the 32-bit pkt_t.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  4  req[i]=1 means requester i holds a valid packet on pkt_in[i].
REQ-007 pkt_in  input  4 x pkt_t (32)  packet offered by each requester; held stable while req[i]=1 and grant[i]=0.
REQ-008 grant  output  4  one-hot, one-cycle pulse; requester i pops its packet when grant[i]=1.
REQ-009 free_outbound  input  1  downstream router/node can accept a packet.
REQ-010 put_outbound  output  1  a byte is valid on payload_outbound this cycle.
REQ-011 payload_outbound  output  8  serialized packet byte.
REQ-012 busy  output  1  a transfer is in progress (state SEND).
REQ-013 sent_count  output  16  number of packets completed since reset.

Function
REQ-014 The FSM SHALL have two states: IDLE and SEND.
REQ-015 In IDLE, at a rising edge with free_outbound=1 and req!=0, the block SHALL perform the following in one edge:
- select a winner by round-robin;
- latch pkt_in[winner] into a shift register;
- register grant=onehot(winner);
- drive put_outbound=1 and payload_outbound=pkt[31:24];
- enter SEND.
REQ-016 In IDLE with free_outbound=0 or req=0, the block SHALL hold: grant=0, put_outbound=0, no state change.
REQ-017 Round-robin: a 2-bit pointer ptr SHALL be searched in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first set req bit wins. On grant, ptr SHALL become winner+1 (mod 4).
REQ-018 grant SHALL be high only in the first SEND cycle (byte 0) and zero in every other cycle.
REQ-019 In SEND, put_outbound SHALL stay high for exactly PKT_BYTES consecutive cycles, carrying bytes [31:24], [23:16], [15:8], [7:0] in that order. A 2-bit byte counter tracks position and wraps from 3 to 0.
REQ-020 At the edge ending byte 3, the block SHALL perform the following:
- drive put_outbound=0;
- return to IDLE;
- increment sent_count, which wraps from 16'hFFFF to 0.
REQ-021 free_outbound and req SHALL be sampled only in IDLE. A transfer, once started, SHALL complete all 4 bytes regardless of changes to free_outbound, req or pkt_in.
REQ-022 Consecutive packets SHALL be separated by exactly one IDLE (put_outbound=0) cycle, the arbitration cycle. Under continuous eligibility, a packet starts every 5 cycles.
REQ-023 busy SHALL equal (state==SEND) and SHALL be registered.
REQ-024 payload_outbound SHALL hold its last value when put_outbound=0; its value is don't-care there.

Reset
REQ-025 When reset=1 at a rising edge, the block SHALL set:
- state=IDLE, ptr=0, byte counter=0;
- grant=0, put_outbound=0, busy=0;
- payload_outbound=8'h00, sent_count=0.
REQ-026 Reset asserted mid-transfer SHALL abort the packet. put_outbound is 0 in the next cycle, and the partial packet does not increment sent_count.
REQ-027 Reset SHALL take priority over every other event at the same edge.

Verification
REQ-028 Single requester: req=0001, pkt_in[0]=32'hDEADBEEF, free=1 -> grant=0001 for one cycle; put=1 for 4 cycles with payload DE,AD,BE,EF; then put=0; sent_count=1.
REQ-029 All requesting: req=1111 held, free=1, distinct packets -> grants 0001, 0010, 0100, 1000, 0001 in that order. Each grant starts a 4-byte burst, and bursts are separated by exactly one idle cycle.
REQ-030 Backpressure: req=0100, free=0 for 10 cycles -> no grant, no put; free rises -> grant=0100 and byte 0 in the cycle after the first edge with free=1.
REQ-031 free_outbound drops after byte 1 -> bytes 2 and 3 are still sent. With free held 0 afterwards, no new packet starts.
REQ-032 Reset asserted during byte 2 -> next cycle put=0, grant=0, busy=0, sent_count=0. After release with req=1001, port 0 wins first, then port 3.
REQ-033 Counter wrap: force 65536 completed packets -> sent_count returns to 16'h0000 with no glitch on put_outbound.
